// File: rtl/instr_sequencer_pkg.sv
// Shared processor definitions: opcode encodings and instruction sequencer FSM states.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_MVNZ = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_IMM,
    S_IMM_WAIT,
    S_ISSUE,
    S_HALT,
    S_ERROR
  } state_t;

endpackage

// File: rtl/instr_sequencer.sv
// Fetches instruction words (plus MVI immediates) from an external synchronous ROM
// and issues them to the processor controller with a run/done handshake and timeout.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [8:0]        mem_data,
  output logic [8:0]        ir,
  output logic [8:0]        din,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [CNT_W-1:0]  tcnt;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc + ADDR_W'(1);

  // mem_addr is loaded on entry to FETCH/IMM so the ROM samples it at the end of that
  // state and the word is on mem_data throughout the following WAIT/IMM_WAIT cycle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= S_IDLE;
      pc       <= '0;
      mem_addr <= '0;
      ir       <= '0;
      din      <= '0;
      run      <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
      tcnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            mem_addr <= pc;
            busy     <= 1'b1;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          ir <= mem_data;
          pc <= pc_inc;
          case (opcode_t'(mem_data[8:6]))
            OP_HALT: begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            OP_MVI: begin
              state    <= S_IMM;
              mem_addr <= pc_inc;
            end
            default: begin
              state <= S_ISSUE;
              run   <= 1'b1;
            end
          endcase
        end
        S_IMM: state <= S_IMM_WAIT;
        S_IMM_WAIT: begin
          din   <= mem_data;
          pc    <= pc_inc;
          state <= S_ISSUE;
          run   <= 1'b1;
        end
        S_ISSUE: begin
          if (done) begin
            state    <= S_FETCH;
            mem_addr <= pc;
            run      <= 1'b0;
            tcnt     <= '0;
          end else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
            state <= S_ERROR;
            run   <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        S_HALT:  state <= S_HALT;
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a synchronous ROM model and hand-computed expectations.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       done = 1'b0;
  logic [4:0] mem_addr;
  logic [8:0] mem_data;
  logic [8:0] ir;
  logic [8:0] din;
  logic       run;
  logic [4:0] pc;
  logic       busy;
  logic       halted;
  logic       err;

  logic [8:0] rom [32];

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] W_MV   = 9'b000001000;
  localparam logic [8:0] W_MVI2 = 9'b001010000;
  localparam logic [8:0] W_MVI1 = 9'b001001000;
  localparam logic [8:0] W_ADD  = 9'b010001010;
  localparam logic [8:0] W_HALT = 9'b111000000;

  instr_sequencer #(.ADDR_W(5), .TIMEOUT(15)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .ir       (ir),
    .din      (din),
    .run      (run),
    .done     (done),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted),
    .err      (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) mem_data <= rom[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start  = 1'b0;
    done   = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Current cycle is cycle 1 (start or done asserted); n is the cycle in which run is seen high.
  task automatic launch(input bit by_start, input bit spurious, output int n);
    if (by_start) start = 1'b1;
    else done = 1'b1;
    tick();
    start = 1'b0;
    done  = spurious;
    n = 2;
    while (!run && n < 40) begin
      tick();
      done = 1'b0;
      n++;
    end
    done = 1'b0;
    if (!run) check("run_rise_timeout", 32'(run), 1);
  endtask

  // Counts cycles run stays high; done is driven in run cycle done_at (0 = never).
  task automatic count_run(input int done_at, output int len, output bit stable);
    logic [8:0] ir0;
    ir0 = ir;
    len = 0;
    stable = 1'b1;
    while (run && len < 40) begin
      len++;
      if (ir !== ir0) stable = 1'b0;
      if (len == done_at) done = 1'b1;
      tick();
      done = 1'b0;
    end
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (!halted && n < 20) begin
      tick();
      n++;
    end
    check("halted", 32'(halted), 1);
  endtask

  initial begin
    int  n;
    int  len;
    bit  stable;

    foreach (rom[i]) rom[i] = 9'd0;

    // Reset state
    do_reset();
    check("rst_state", 32'(dut.state), 32'(S_IDLE));
    check("rst_pc", 32'(pc), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_ir", 32'(ir), 0);
    check("rst_din", 32'(din), 0);
    check("rst_run", 32'(run), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_err", 32'(err), 0);

    // MV then HALT
    rom[0] = W_MV;
    rom[1] = W_HALT;
    launch(1'b1, 1'b0, n);
    check("mv_latency", 32'(n), 4);
    check("mv_ir", 32'(ir), 'b000001000);
    check("mv_busy", 32'(busy), 1);
    count_run(3, len, stable);
    check("mv_run_len", 32'(len), 3);
    check("mv_ir_stable", 32'(stable), 1);
    check("mv_run_fall", 32'(run), 0);
    wait_halt();
    check("mv_halt_pc", 32'(pc), 2);
    check("mv_halt_busy", 32'(busy), 0);

    // MVI immediate then HALT
    do_reset();
    rom[0] = W_MVI2;
    rom[1] = 9'd5;
    rom[2] = W_HALT;
    launch(1'b1, 1'b0, n);
    check("mvi_latency", 32'(n), 6);
    check("mvi_din", 32'(din), 5);
    check("mvi_ir", 32'(ir), 'b001010000);
    check("mvi_pc", 32'(pc), 2);
    count_run(1, len, stable);
    wait_halt();
    check("mvi_halt_pc", 32'(pc), 3);

    // MVI, then ADD with a spurious done in FETCH; din must hold across ADD
    do_reset();
    rom[0] = W_MVI1;
    rom[1] = 9'd7;
    rom[2] = W_ADD;
    rom[3] = W_HALT;
    launch(1'b1, 1'b0, n);
    check("add_mvi_din", 32'(din), 7);
    launch(1'b0, 1'b1, n);
    check("done_latency", 32'(n), 4);
    check("add_ir", 32'(ir), 'b010001010);
    check("add_din_hold", 32'(din), 7);
    check("add_pc", 32'(pc), 3);
    count_run(3, len, stable);
    check("add_run_len", 32'(len), 3);
    wait_halt();
    check("add_halt_pc", 32'(pc), 4);

    // Timeout: done never asserted
    do_reset();
    rom[0] = W_ADD;
    launch(1'b1, 1'b0, n);
    count_run(0, len, stable);
    check("to_run_len", 32'(len), 15);
    check("to_err", 32'(err), 1);
    check("to_run", 32'(run), 0);
    check("to_busy", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("to_start_ignored_err", 32'(err), 1);
    check("to_start_ignored_busy", 32'(busy), 0);
    check("to_start_ignored_pc", 32'(pc), 1);
    check("to_start_ignored_run", 32'(run), 0);

    // pc wrap: 32 MV words, ROM[0] becomes HALT after its first fetch
    do_reset();
    foreach (rom[i]) rom[i] = W_MV;
    launch(1'b1, 1'b0, n);
    rom[0] = W_HALT;
    for (int i = 2; i <= 32; i++) begin
      launch(1'b0, 1'b0, n);
      if (i == 31) check("wrap_pc31", 32'(pc), 31);
    end
    check("wrap_pc0", 32'(pc), 0);
    check("wrap_ir", 32'(ir), 'b000001000);
    count_run(1, len, stable);
    wait_halt();
    check("wrap_halt_pc", 32'(pc), 1);

    // Reset while run is high, then restart from address 0
    do_reset();
    foreach (rom[i]) rom[i] = 9'd0;
    rom[0] = W_ADD;
    rom[1] = W_HALT;
    launch(1'b1, 1'b0, n);
    check("mid_run_before", 32'(run), 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("mid_run", 32'(run), 0);
    check("mid_pc", 32'(pc), 0);
    check("mid_state", 32'(dut.state), 32'(S_IDLE));
    check("mid_ir", 32'(ir), 0);
    tick();
    tick();
    check("mid_idle_busy", 32'(busy), 0);
    check("mid_idle_mem_addr", 32'(mem_addr), 0);
    launch(1'b1, 1'b0, n);
    check("mid_restart_latency", 32'(n), 4);
    check("mid_restart_ir", 32'(ir), 'b010001010);
    check("mid_restart_pc", 32'(pc), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
